// File: rtl/lambo_ctrl_fsm.sv
// lambo_ctrl_fsm: fetch/decode/execute sequencer for the Lambo core; owns PC, IR, compare flag, retire count.
// Latency: FETCH->FETCH is 2 cycles (CMP/BRANCH), 3 (ALU ops), 2+N (STR), 3+N (LDR), N = MEM cycles incl. ack.
// Backpressure: mem_req held until mem_ack; after MEM_TMO cycles without ack the program aborts to DONE with err.

module lambo_ctrl_fsm #(
    parameter int INSTR_W  = 9,
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1023,
    parameter int MEM_TMO  = 15,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [2:0]         alu_op,
    output logic               alu_en,
    input  logic               cmp_in,
    output logic               reg_we,
    output logic               mem_req,
    output logic               mem_we,
    input  logic               mem_ack,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   retired
);

    localparam int OPND_W = INSTR_W - 3;
    localparam int TMO_W  = $clog2(MEM_TMO + 1);

    localparam logic [2:0] OP_CMP    = 3'd0;
    localparam logic [2:0] OP_BRANCH = 3'd1;
    localparam logic [2:0] OP_LDR    = 3'd2;
    localparam logic [2:0] OP_STR    = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_t;

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic               flag;
    logic [TMO_W-1:0]   tmo_cnt;

    logic [2:0]         op;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_br;
    logic [CNT_W-1:0]   ret_next;

    // Decode helpers: opcode field, sequential and branch targets (wrap mod 2**PC_W), saturating retire count
    assign op       = ir[INSTR_W-1 -: 3];
    assign pc_inc   = pc + PC_W'(1);
    assign pc_br    = pc + {{(PC_W-OPND_W){ir[OPND_W-1]}}, ir[OPND_W-1:0]};
    assign ret_next = (retired == {CNT_W{1'b1}}) ? retired : retired + CNT_W'(1);

    // Sequencer: state, architectural registers, and strobes registered on entry to the state that owns them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            flag    <= 1'b0;
            retired <= '0;
            err     <= 1'b0;
            tmo_cnt <= '0;
            alu_op  <= 3'd0;
            alu_en  <= 1'b0;
            reg_we  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            // Single-state strobes drop unless the transition below re-enters a state that drives them
            alu_en  <= 1'b0;
            reg_we  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        pc      <= '0;
                        retired <= '0;
                        err     <= 1'b0;
                        flag    <= 1'b0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pc == PC_W'(PROG_LEN)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        ir     <= instr;
                        alu_en <= 1'b1;
                        alu_op <= instr[INSTR_W-1 -: 3];
                        state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_CMP: begin
                            flag    <= cmp_in;
                            pc      <= pc_inc;
                            retired <= ret_next;
                            state   <= S_FETCH;
                        end
                        OP_BRANCH: begin
                            pc      <= flag ? pc_br : pc_inc;
                            retired <= ret_next;
                            state   <= S_FETCH;
                        end
                        OP_LDR, OP_STR: begin
                            tmo_cnt <= '0;
                            mem_req <= 1'b1;
                            mem_we  <= (op == OP_STR);
                            state   <= S_MEM;
                        end
                        default: begin
                            reg_we <= 1'b1;
                            state  <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (op == OP_STR) begin
                            pc      <= pc_inc;
                            retired <= ret_next;
                            state   <= S_FETCH;
                        end else begin
                            reg_we <= 1'b1;
                            state  <= S_WB;
                        end
                    end else if (tmo_cnt == TMO_W'(MEM_TMO - 1)) begin
                        // Abort leaves pc on the faulting instruction for debug
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                        mem_req <= 1'b1;
                        mem_we  <= mem_we;
                    end
                end
                S_WB: begin
                    pc      <= pc_inc;
                    retired <= ret_next;
                    state   <= S_FETCH;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lambo_ctrl_fsm.sv
// Bench for lambo_ctrl_fsm: instruction-level reference model feeds an event scoreboard;
// a negedge monitor pops and compares EXEC / MEM / WB / DONE events as the DUT shows them.
module tb_lambo_ctrl_fsm;

    localparam int INSTR_W  = 9;
    localparam int PC_W     = 10;
    localparam int PROG_LEN = 3;
    localparam int MEM_TMO  = 15;
    localparam int CNT_W    = 4;
    localparam int PC_MOD   = 1 << PC_W;
    localparam int RET_MAX  = (1 << CNT_W) - 1;

    localparam int OP_CMP = 0, OP_BRANCH = 1, OP_LDR = 2, OP_STR = 3;
    localparam int OP_XOR = 4, OP_ADD = 5, OP_SUB = 6, OP_LSH = 7;
    localparam int EV_EXEC = 0, EV_MEM = 1, EV_WB = 2, EV_DONE = 3;

    typedef struct {
        int kind;
        int pc;
        int a;
        int b;
        int c;
    } ev_t;

    logic               clk = 1'b0;
    logic               reset, start, cmp_in, mem_ack;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [2:0]         alu_op;
    logic               alu_en, reg_we, mem_req, mem_we, busy, done, err;
    logic [CNT_W-1:0]   retired;

    logic [INSTR_W-1:0] rom [PC_MOD];

    ev_t exp_q[$];
    ev_t mdl_q[$];
    int  cmp_vals[$];
    int  dly_vals[$];
    int  errors = 0, checks = 0;
    int  cyc = 0, start_cyc = 0, prog_id = 0;
    bit  mon_en = 1'b1;

    assign instr = rom[pc];
    always #5 clk = ~clk;

    lambo_ctrl_fsm #(
        .INSTR_W(INSTR_W), .PC_W(PC_W), .PROG_LEN(PROG_LEN), .MEM_TMO(MEM_TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .pc(pc),
        .alu_op(alu_op), .alu_en(alu_en), .cmp_in(cmp_in), .reg_we(reg_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .busy(busy),
        .done(done), .err(err), .retired(retired)
    );

    function automatic string ev_name(int k);
        case (k)
            EV_EXEC: return "exec";
            EV_MEM:  return "mem";
            EV_WB:   return "wb";
            default: return "done";
        endcase
    endfunction

    function automatic logic [INSTR_W-1:0] mk(int op, int opnd);
        logic [INSTR_W-1:0] r;
        r[8:6] = op[2:0];
        r[5:0] = opnd[5:0];
        return r;
    endfunction

    task automatic chk(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic sb_check(int k, int p, int a, int b, int c);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_%s: got pc=%0d a=%0d b=%0d c=%0d, required no event", ev_name(k), p, a, b, c);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.pc != p || e.a != a || e.b != b || e.c != c) begin
                errors++;
                $display("FAIL sb_%s: got %s pc=%0d a=%0d b=%0d c=%0d, required %s pc=%0d a=%0d b=%0d c=%0d",
                         ev_name(e.kind), ev_name(k), p, a, b, c, ev_name(e.kind), e.pc, e.a, e.b, e.c);
            end
        end
    endtask

    task automatic mpush(int k, int p, int a, int b, int c);
        ev_t e;
        e.kind = k; e.pc = p; e.a = a; e.b = b; e.c = c;
        mdl_q.push_back(e);
    endtask

    // Instruction-level reference: walks the ROM with plain arithmetic, producing the event trace
    // (MEM: a=is_store, b=MEM cycles; DONE: a=retired, b=err, c=cycles after the start edge).
    task automatic model_run(output bit ok);
        int p = 0, flag = 0, ret = 0, cy = 0, c_i = 0, m_i = 0, steps = 0;
        int op, opnd, off, n;
        bit fin = 1'b0;
        mdl_q.delete();
        ok = 1'b0;
        while (!fin && steps < 60) begin
            if (p == PROG_LEN) begin
                cy += 1;
                mpush(EV_DONE, p, ret, 0, cy);
                fin = 1'b1;
                ok  = 1'b1;
            end else begin
                op   = int'(rom[p][8:6]);
                opnd = int'(rom[p][5:0]);
                mpush(EV_EXEC, p, op, 0, 0);
                steps++;
                case (op)
                    OP_CMP: begin
                        flag = cmp_vals[c_i];
                        c_i++;
                        p = (p + 1) % PC_MOD;
                        ret = (ret < RET_MAX) ? ret + 1 : ret;
                        cy += 2;
                    end
                    OP_BRANCH: begin
                        off = (opnd >= 32) ? opnd - 64 : opnd;
                        p = (flag != 0) ? (p + off + PC_MOD) % PC_MOD : (p + 1) % PC_MOD;
                        ret = (ret < RET_MAX) ? ret + 1 : ret;
                        cy += 2;
                    end
                    OP_LDR, OP_STR: begin
                        n = dly_vals[m_i];
                        m_i++;
                        if (n == 0) begin
                            mpush(EV_MEM, p, (op == OP_STR) ? 1 : 0, MEM_TMO, 0);
                            cy += 2 + MEM_TMO;
                            mpush(EV_DONE, p, ret, 1, cy);
                            fin = 1'b1;
                            ok  = 1'b1;
                        end else begin
                            mpush(EV_MEM, p, (op == OP_STR) ? 1 : 0, n, 0);
                            if (op == OP_LDR) begin
                                mpush(EV_WB, p, 0, 0, 0);
                                cy += 3 + n;
                            end else begin
                                cy += 2 + n;
                            end
                            p = (p + 1) % PC_MOD;
                            ret = (ret < RET_MAX) ? ret + 1 : ret;
                        end
                    end
                    default: begin
                        mpush(EV_WB, p, 0, 0, 0);
                        cy += 3;
                        p = (p + 1) % PC_MOD;
                        ret = (ret < RET_MAX) ? ret + 1 : ret;
                    end
                endcase
            end
        end
    endtask

    task automatic fill_stim();
        int r;
        cmp_vals.delete();
        dly_vals.delete();
        for (int i = 0; i < 64; i++) begin
            cmp_vals.push_back(int'($urandom % 2));
            r = int'($urandom % 20);
            dly_vals.push_back((r == 0) ? 0 : (r == 1) ? MEM_TMO : int'($urandom_range(5, 1)));
        end
    endtask

    task automatic fill_rom_random();
        int op, v;
        for (int i = 0; i < PC_MOD; i++) begin
            op = int'($urandom % 8);
            v  = (op == OP_BRANCH) ? int'($urandom_range(8, 0)) - 4 : int'($urandom % 64);
            rom[i] = mk(op, v);
        end
    endtask

    // Reactive stimulus: cmp value per executed CMP, ack after the scheduled number of MEM cycles,
    // random noise on both inputs whenever the DUT is not sampling them.
    task automatic driver_loop();
        int seen = -1, ci = 0, mi = 0, mcnt = 0;
        forever begin
            @(negedge clk);
            if (prog_id != seen) begin
                seen = prog_id; ci = 0; mi = 0; mcnt = 0;
            end
            if (alu_en && alu_op == 3'd0 && ci < cmp_vals.size()) begin
                cmp_in = (cmp_vals[ci] != 0);
                ci++;
            end else begin
                cmp_in = ($urandom % 2) == 1;
            end
            if (mem_req) begin
                mcnt++;
                mem_ack = (mi < dly_vals.size()) && (dly_vals[mi] != 0) && (mcnt == dly_vals[mi]);
            end else begin
                if (mcnt != 0) begin
                    mi++;
                    mcnt = 0;
                end
                mem_ack = ($urandom % 4) == 0;
            end
        end
    endtask

    task automatic monitor_loop();
        int   mlen = 0, mpc = 0, mwe = 0;
        logic done_q = 1'b0;
        forever begin
            @(negedge clk);
            if (reset || !mon_en) begin
                mlen   = 0;
                done_q = done;
            end else begin
                if (mem_req) begin
                    if (mlen == 0) begin
                        mpc = int'(pc);
                        mwe = int'(mem_we);
                    end
                    mlen++;
                end else if (mlen != 0) begin
                    sb_check(EV_MEM, mpc, mwe, mlen, 0);
                    mlen = 0;
                end
                if (alu_en) sb_check(EV_EXEC, int'(pc), int'(alu_op), 0, 0);
                if (reg_we) sb_check(EV_WB, int'(pc), 0, 0, 0);
                if (done && !done_q) sb_check(EV_DONE, int'(pc), int'(retired), int'(err), cyc - start_cyc);
                done_q = done;
            end
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        prog_id++;
        start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic launch(string name);
        exp_q = mdl_q;
        start_pulse();
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        @(negedge clk);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done=0 after 3000 cycles, required done=1", name);
            exp_q.delete();
        end else begin
            chk({name, "_drain"}, exp_q.size(), 0);
        end
    endtask

    initial begin
        bit ok;
        reset   = 1'b1;
        start   = 1'b0;
        cmp_in  = 1'b0;
        mem_ack = 1'b0;
        fill_rom_random();
        fill_stim();
        fork
            driver_loop();
            monitor_loop();
            forever begin
                @(posedge clk);
                cyc++;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_pc", int'(pc), 0);
        chk("rst_alu_en", int'(alu_en), 0);
        chk("rst_reg_we", int'(reg_we), 0);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_retired", int'(retired), 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_pc", int'(pc), 0);

        // ALU-only program: three reg_we pulses, done 10 cycles after the start edge
        rom[0] = mk(OP_ADD, 1); rom[1] = mk(OP_XOR, 2); rom[2] = mk(OP_SUB, 3);
        fill_stim();
        model_run(ok);
        launch("alu3");
        chk("alu3_retired", int'(retired), 3);

        // CMP true then BRANCH -1 back to 0; second pass CMP false falls through
        rom[0] = mk(OP_CMP, 0); rom[1] = mk(OP_BRANCH, -1); rom[2] = mk(OP_ADD, 0);
        fill_stim();
        cmp_vals[0] = 1; cmp_vals[1] = 0;
        model_run(ok);
        launch("branch_back");

        // LDR acked on the third MEM cycle
        rom[0] = mk(OP_LDR, 5); rom[1] = mk(OP_ADD, 0); rom[2] = mk(OP_XOR, 0);
        fill_stim();
        dly_vals[0] = 3;
        model_run(ok);
        launch("ldr3");
        chk("ldr3_pc", int'(pc), PROG_LEN);

        // STR never acked: timeout abort with err, retire count unchanged
        rom[0] = mk(OP_ADD, 0); rom[1] = mk(OP_STR, 7); rom[2] = mk(OP_ADD, 0);
        fill_stim();
        dly_vals[0] = 0;
        model_run(ok);
        launch("str_tmo");
        chk("str_tmo_err", int'(err), 1);
        chk("str_tmo_retired", int'(retired), 1);
        chk("str_tmo_pc", int'(pc), 1);

        // Branch -2 from pc 1 lands on 1023; ADD there wraps pc to 0
        rom[0] = mk(OP_CMP, 0); rom[1] = mk(OP_BRANCH, -2); rom[2] = mk(OP_XOR, 0);
        rom[PC_MOD-1] = mk(OP_ADD, 0);
        fill_stim();
        cmp_vals[0] = 1; cmp_vals[1] = 0;
        model_run(ok);
        launch("wrap");
        chk("wrap_err_cleared", int'(err), 0);

        // Branch offset 0 spins forever; retired saturates; start while busy is ignored
        mon_en = 1'b0;
        rom[0] = mk(OP_CMP, 0); rom[1] = mk(OP_BRANCH, 0);
        fill_stim();
        cmp_vals[0] = 1;
        start_pulse();
        repeat (60) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("spin_retired_sat", int'(retired), RET_MAX);
        chk("spin_busy", int'(busy), 1);
        chk("spin_done", int'(done), 0);
        #2 reset = 1'b1;
        #1 chk("spin_rst_pc", int'(pc), 0);
        @(negedge clk);
        reset = 1'b0;

        // Reset asserted in the middle of a memory wait
        rom[0] = mk(OP_ADD, 0); rom[1] = mk(OP_XOR, 0); rom[2] = mk(OP_LDR, 9);
        fill_stim();
        dly_vals[0] = 0;
        start_pulse();
        for (int i = 0; i < 30 && !mem_req; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("midmem_req_before", int'(mem_req), 1);
        chk("midmem_pc_before", int'(pc), 2);
        #2 reset = 1'b1;
        #1;
        chk("midmem_req_after", int'(mem_req), 0);
        chk("midmem_pc_after", int'(pc), 0);
        chk("midmem_busy_after", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk("midmem_idle_busy", int'(busy), 0);
        chk("midmem_idle_done", int'(done), 0);
        chk("midmem_idle_pc", int'(pc), 0);
        mon_en = 1'b1;

        // Random programs with random compare outcomes and memory latencies
        for (int r = 0; r < 25; r++) begin
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok; t++) begin
                fill_rom_random();
                fill_stim();
                model_run(ok);
            end
            if (ok) launch($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
